armleocpu_decode: RTL and testbench
===================================

# armleocpu_decode

Decode stage of the 3-stage ArmleoCPU pipeline. It sits between fetch and execute.
- Accepts instruction words or interrupt-pending tokens from fetch over the F2D bus.
- Registers them with extracted RISC-V fields into a single-entry D2E pipeline register.
- Relays execute's branch/flush commands back to fetch over D2F, combinationally, in the same cycle.
- Serializes the pipeline around SYSTEM and MISC-MEM instructions so fetch stops issuing until execute redirects it.

## Interface
Parameters: none. Encodings come from `armleocpu_defines.vh`: `F2E_TYPE_*`, `ARMLEOCPU_D2F_CMD_*`, `F2E_TYPE_WIDTH`, `ARMLEOCPU_D2F_CMD_WIDTH`.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- f2d_valid  in  1  fetch has an item
- f2d_type  in  F2E_TYPE_WIDTH  INSTR or INTERRUPT_PENDING
- f2d_instr  in  32  instruction word
- f2d_pc  in  32  instruction address
- d2f_ready  out  1  decode accepts the F2D item and D2F command this cycle
- d2f_cmd  out  ARMLEOCPU_D2F_CMD_WIDTH  NONE / FLUSH / START_BRANCH to fetch
- d2f_branchtarget  out  32  branch target, meaningful when d2f_cmd = START_BRANCH
- d2e_valid  out  1  D2E register holds an item
- d2e_type  out  F2E_TYPE_WIDTH  registered type
- d2e_instr  out  32  registered instruction
- d2e_pc  out  32  registered pc
- d2e_rd  out  5  instr[11:7]
- d2e_rs1  out  5  instr[19:15]
- d2e_rs2  out  5  instr[24:20]
- d2e_illegal  out  1  instruction is not a supported RV32I encoding
- d2e_serialize  out  1  item is SYSTEM, MISC-MEM or INTERRUPT_PENDING
- e2d_ready  in  1  execute consumes the D2E item this cycle
- e2d_cmd  in  ARMLEOCPU_D2F_CMD_WIDTH  redirect command from execute
- e2d_branchtarget  in  32  redirect target

## Operation
- **Redirect.** When e2d_cmd != NONE:
  - d2f_ready=1, d2f_cmd=e2d_cmd, d2f_branchtarget=e2d_branchtarget, all combinational.
  - The F2D item presented that cycle is discarded as wrong-path.
  - d2e_valid<=0, unless e2d_ready=0 and the held item is the one that caused the redirect. Execute never redirects while holding a different item.
  - State<=RUN.
- Otherwise d2f_cmd=NONE and d2f_branchtarget=0.
- **States**
  - RUN: d2f_ready = !d2e_valid || e2d_ready.
  - SERIALIZE: d2f_ready=0. Incoming F2D items stay held by fetch. D2E drains normally.
- **Transitions**
  - RUN→SERIALIZE when an accepted item has d2e_serialize=1.
  - SERIALIZE→RUN only on a redirect. Execute guarantees exactly one redirect (START_BRANCH to pc+4, or FLUSH) after each serializing item.
- **Acceptance.** On f2d_valid && d2f_ready && no redirect, the D2E register loads type, instr and pc and sets d2e_valid<=1.
- **Drain.** If e2d_ready and nothing is accepted, d2e_valid<=0.
- **Field decode.** Fields are decoded from the registered word, so they are stable while d2e_valid=1 && !e2d_ready.
- **Serialize detect.** opcode[6:0] = 1110011 (SYSTEM) or 0001111 (MISC-MEM), or type = INTERRUPT_PENDING.
- **INTERRUPT_PENDING items.** d2e_illegal=0; rd/rs fields are don't-care.

## Timing
- **Latency.** 1 cycle from F2D acceptance to d2e_valid.
- **Throughput.** 1 item per cycle when e2d_ready is held at 1.
- **D2F path.** d2f_ready, d2f_cmd and d2f_branchtarget are combinational from e2d_*, state and d2e_valid. There is no register on the D2F path.
- **During rst=1**
  - d2f_ready=0, d2f_cmd=NONE.
  - d2e_valid<=0, state<=RUN, D2E data<=0.
  - All D2E outputs read 0 on the first cycle after reset.
- **Reset mid-operation.** Drops the held item and any SERIALIZE state without a redirect.
- **Hold rule.** D2E outputs stay constant while d2e_valid && !e2d_ready.
- **Simultaneous events**
  - A redirect and f2d_valid in the same cycle: the redirect wins and the F2D item is dropped.
  - A redirect and e2d_ready in the same cycle: the item is consumed and d2e_valid<=0.

## Configuration
- `ARMLEOCPU_DECODE_ILLEGAL_CHECK_EN`
  - Defined: d2e_illegal=1 when any of the following holds:
    - instr[1:0] != 11;
    - opcode is not one of LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, MISC-MEM, SYSTEM;
    - funct3 is invalid for BRANCH (010, 011), LOAD (011, 110, 111) or STORE (>010);
    - OP-IMM shift or OP funct7 is not 0000000/0100000 (0100000 only for SUB/SRA/SRAI);
    - JALR funct3 != 000.
  - Undefined: d2e_illegal is tied to 0. Execute handles all checking.

## Test plan
- **Streaming.** Fetch streams ADDI at pc 0x1000, 0x1004, 0x1008 with e2d_ready=1. Expect:
  - d2e_valid high from cycle 1;
  - d2e_pc = 0x1000, 0x1004, 0x1008 on consecutive cycles;
  - d2f_ready=1 throughout.
- **Backpressure.** e2d_ready=0 for 3 cycles with d2e holding instr 0x00500093. Expect:
  - d2e outputs unchanged;
  - d2f_ready=0;
  - the next item is accepted the cycle e2d_ready returns to 1.
- **Serialize.** CSRRW (0x34011073) is accepted. Expect:
  - state goes to SERIALIZE and d2f_ready=0 while f2d_valid=1.
  - Then e2d_cmd=START_BRANCH with target 0x2004. Expect d2f_cmd=START_BRANCH, d2f_branchtarget=0x2004, d2f_ready=1 in the same cycle, and a return to RUN.
- **Redirect collision.** e2d_cmd=FLUSH in the same cycle as f2d_valid=1 (pc 0x300). Expect:
  - d2f_cmd=FLUSH;
  - the item at pc 0x300 is never seen on D2E;
  - d2e_valid=0 the next cycle.
- **Illegal check.** With the macro defined, instr 0x00000000 sets d2e_illegal=1 and 0x0000006F (JAL) sets d2e_illegal=0. Without the macro, both give 0.
- **Reset mid-serialize.** Assert rst for 1 cycle while in SERIALIZE with d2e_valid=1. Expect d2e_valid=0, d2f_cmd=NONE, and d2f_ready=1 on the first cycle after reset.

Source files
------------

// File: rtl/armleocpu_decode.sv
// Decode stage of the ArmleoCPU pipeline: F2D intake, single-entry D2E register, D2F redirect relay.
// Define ARMLEOCPU_DECODE_ILLEGAL_CHECK_EN to enable RV32I illegal-instruction detection.

`ifndef F2E_TYPE_WIDTH
`define F2E_TYPE_WIDTH 2
`define F2E_TYPE_INSTR 2'd0
`define F2E_TYPE_INTERRUPT_PENDING 2'd1
`endif

`ifndef ARMLEOCPU_D2F_CMD_WIDTH
`define ARMLEOCPU_D2F_CMD_WIDTH 2
`define ARMLEOCPU_D2F_CMD_NONE 2'd0
`define ARMLEOCPU_D2F_CMD_START_BRANCH 2'd1
`define ARMLEOCPU_D2F_CMD_FLUSH 2'd2
`endif

module armleocpu_decode (
    input  logic                                clk,
    input  logic                                rst,

    input  logic                                f2d_valid,
    input  logic [`F2E_TYPE_WIDTH-1:0]          f2d_type,
    input  logic [31:0]                         f2d_instr,
    input  logic [31:0]                         f2d_pc,
    output logic                                d2f_ready,
    output logic [`ARMLEOCPU_D2F_CMD_WIDTH-1:0] d2f_cmd,
    output logic [31:0]                         d2f_branchtarget,

    output logic                                d2e_valid,
    output logic [`F2E_TYPE_WIDTH-1:0]          d2e_type,
    output logic [31:0]                         d2e_instr,
    output logic [31:0]                         d2e_pc,
    output logic [4:0]                          d2e_rd,
    output logic [4:0]                          d2e_rs1,
    output logic [4:0]                          d2e_rs2,
    output logic                                d2e_illegal,
    output logic                                d2e_serialize,
    input  logic                                e2d_ready,
    input  logic [`ARMLEOCPU_D2F_CMD_WIDTH-1:0] e2d_cmd,
    input  logic [31:0]                         e2d_branchtarget
);

    // Handshakes: an item moves across F2D when f2d_valid && d2f_ready (and no redirect),
    // and across D2E when d2e_valid && e2d_ready; a valid item is held stable until taken.
    typedef enum logic {
        STATE_RUN       = 1'b0,
        STATE_SERIALIZE = 1'b1
    } state_t;

    state_t                       state_q, state_d;
    logic                         d2e_valid_q, d2e_valid_d;
    logic [`F2E_TYPE_WIDTH-1:0]   d2e_type_q, d2e_type_d;
    logic [31:0]                  d2e_instr_q, d2e_instr_d;
    logic [31:0]                  d2e_pc_q, d2e_pc_d;
    logic                         redirect;
    logic                         run_ready;
    logic                         f2d_serialize;
    logic                         d2e_is_serialize;

    assign redirect = (e2d_cmd != `ARMLEOCPU_D2F_CMD_NONE);

    assign f2d_serialize = (f2d_type == `F2E_TYPE_INTERRUPT_PENDING) ||
                           (f2d_instr[6:0] == 7'b1110011) ||
                           (f2d_instr[6:0] == 7'b0001111);

    always_comb begin
        state_d          = state_q;
        d2e_valid_d      = d2e_valid_q;
        d2e_type_d       = d2e_type_q;
        d2e_instr_d      = d2e_instr_q;
        d2e_pc_d         = d2e_pc_q;
        d2f_ready        = 1'b0;
        d2f_cmd          = `ARMLEOCPU_D2F_CMD_NONE;
        d2f_branchtarget = 32'd0;
        run_ready        = (state_q == STATE_RUN) && (!d2e_valid_q || e2d_ready);

        if (!rst) begin
            if (redirect) begin
                // Redirect wins over any F2D item; a held item only survives if execute keeps it.
                d2f_ready        = 1'b1;
                d2f_cmd          = e2d_cmd;
                d2f_branchtarget = e2d_branchtarget;
                d2e_valid_d      = d2e_valid_q && !e2d_ready;
                state_d          = STATE_RUN;
            end else begin
                d2f_ready = run_ready;
                if (f2d_valid && run_ready) begin
                    d2e_valid_d = 1'b1;
                    d2e_type_d  = f2d_type;
                    d2e_instr_d = f2d_instr;
                    d2e_pc_d    = f2d_pc;
                    if (f2d_serialize) begin
                        state_d = STATE_SERIALIZE;
                    end
                end else if (e2d_ready) begin
                    d2e_valid_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= STATE_RUN;
            d2e_valid_q <= 1'b0;
            d2e_type_q  <= '0;
            d2e_instr_q <= 32'd0;
            d2e_pc_q    <= 32'd0;
        end else begin
            state_q     <= state_d;
            d2e_valid_q <= d2e_valid_d;
            d2e_type_q  <= d2e_type_d;
            d2e_instr_q <= d2e_instr_d;
            d2e_pc_q    <= d2e_pc_d;
        end
    end

    assign d2e_is_serialize = (d2e_type_q == `F2E_TYPE_INTERRUPT_PENDING) ||
                              (d2e_instr_q[6:0] == 7'b1110011) ||
                              (d2e_instr_q[6:0] == 7'b0001111);

    assign d2e_valid     = d2e_valid_q;
    assign d2e_type      = d2e_type_q;
    assign d2e_instr     = d2e_instr_q;
    assign d2e_pc        = d2e_pc_q;
    assign d2e_rd        = d2e_instr_q[11:7];
    assign d2e_rs1       = d2e_instr_q[19:15];
    assign d2e_rs2       = d2e_instr_q[24:20];
    assign d2e_serialize = d2e_is_serialize;

`ifdef ARMLEOCPU_DECODE_ILLEGAL_CHECK_EN
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       instr_illegal;

    assign opcode = d2e_instr_q[6:0];
    assign funct3 = d2e_instr_q[14:12];
    assign funct7 = d2e_instr_q[31:25];

    always_comb begin
        instr_illegal = 1'b0;
        if (d2e_instr_q[1:0] != 2'b11) begin
            instr_illegal = 1'b1;
        end else begin
            case (opcode)
                7'b0110111, 7'b0010111, 7'b1101111: instr_illegal = 1'b0;
                7'b1100111: instr_illegal = (funct3 != 3'b000);
                7'b1100011: instr_illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
                7'b0000011: instr_illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
                7'b0100011: instr_illegal = (funct3 > 3'b010);
                7'b0010011: begin
                    if (funct3 == 3'b001) begin
                        instr_illegal = (funct7 != 7'b0000000);
                    end else if (funct3 == 3'b101) begin
                        instr_illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
                    end
                end
                7'b0110011: begin
                    if (funct7 == 7'b0100000) begin
                        instr_illegal = (funct3 != 3'b000) && (funct3 != 3'b101);
                    end else begin
                        instr_illegal = (funct7 != 7'b0000000);
                    end
                end
                7'b0001111, 7'b1110011: instr_illegal = 1'b0;
                default: instr_illegal = 1'b1;
            endcase
        end
    end

    // Gated by valid so the post-reset all-zero word does not report illegal.
    assign d2e_illegal = d2e_valid_q && (d2e_type_q == `F2E_TYPE_INSTR) && instr_illegal;
`else
    assign d2e_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_armleocpu_decode.sv
// Self-checking bench for armleocpu_decode: directed scenarios plus an expected-item queue
// compared whenever execute consumes a D2E item.

`ifndef F2E_TYPE_WIDTH
`define F2E_TYPE_WIDTH 2
`define F2E_TYPE_INSTR 2'd0
`define F2E_TYPE_INTERRUPT_PENDING 2'd1
`endif

`ifndef ARMLEOCPU_D2F_CMD_WIDTH
`define ARMLEOCPU_D2F_CMD_WIDTH 2
`define ARMLEOCPU_D2F_CMD_NONE 2'd0
`define ARMLEOCPU_D2F_CMD_START_BRANCH 2'd1
`define ARMLEOCPU_D2F_CMD_FLUSH 2'd2
`endif

module tb_armleocpu_decode;
    localparam int TW = `F2E_TYPE_WIDTH;
    localparam int CW = `ARMLEOCPU_D2F_CMD_WIDTH;
    localparam logic [TW-1:0] T_INSTR = `F2E_TYPE_INSTR;
    localparam logic [TW-1:0] T_INT   = `F2E_TYPE_INTERRUPT_PENDING;
    localparam logic [CW-1:0] C_NONE  = `ARMLEOCPU_D2F_CMD_NONE;
    localparam logic [CW-1:0] C_BR    = `ARMLEOCPU_D2F_CMD_START_BRANCH;
    localparam logic [CW-1:0] C_FLUSH = `ARMLEOCPU_D2F_CMD_FLUSH;
    localparam logic [31:0]   NOP     = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          rst;
    logic          f2d_valid;
    logic [TW-1:0] f2d_type;
    logic [31:0]   f2d_instr;
    logic [31:0]   f2d_pc;
    logic          d2f_ready;
    logic [CW-1:0] d2f_cmd;
    logic [31:0]   d2f_branchtarget;
    logic          d2e_valid;
    logic [TW-1:0] d2e_type;
    logic [31:0]   d2e_instr;
    logic [31:0]   d2e_pc;
    logic [4:0]    d2e_rd;
    logic [4:0]    d2e_rs1;
    logic [4:0]    d2e_rs2;
    logic          d2e_illegal;
    logic          d2e_serialize;
    logic          e2d_ready;
    logic [CW-1:0] e2d_cmd;
    logic [31:0]   e2d_branchtarget;

    int n_tests = 0;
    int n_fail  = 0;

    // Entry: {type, pc, instr, serialize, illegal}
    logic [TW+65:0] exp_q[$];

    always #5 clk = ~clk;

    armleocpu_decode dut (
        .clk              (clk),
        .rst              (rst),
        .f2d_valid        (f2d_valid),
        .f2d_type         (f2d_type),
        .f2d_instr        (f2d_instr),
        .f2d_pc           (f2d_pc),
        .d2f_ready        (d2f_ready),
        .d2f_cmd          (d2f_cmd),
        .d2f_branchtarget (d2f_branchtarget),
        .d2e_valid        (d2e_valid),
        .d2e_type         (d2e_type),
        .d2e_instr        (d2e_instr),
        .d2e_pc           (d2e_pc),
        .d2e_rd           (d2e_rd),
        .d2e_rs1          (d2e_rs1),
        .d2e_rs2          (d2e_rs2),
        .d2e_illegal      (d2e_illegal),
        .d2e_serialize    (d2e_serialize),
        .e2d_ready        (e2d_ready),
        .e2d_cmd          (e2d_cmd),
        .e2d_branchtarget (e2d_branchtarget)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Scoreboard: compare every item execute takes against the oldest expected item.
    always @(negedge clk) begin
        if (!rst && d2e_valid && e2d_ready) begin
            if (exp_q.size() == 0) begin
                check("d2e_unexpected_item_pc", d2e_pc, 32'hDEAD_BEEF);
            end else begin
                logic [TW+65:0] e;
                logic [31:0]    ei;
                e  = exp_q.pop_front();
                ei = e[33:2];
                check("sb_type", 32'(d2e_type), 32'(e[TW+65:66]));
                check("sb_pc", d2e_pc, e[65:34]);
                check("sb_serialize", 32'(d2e_serialize), 32'(e[1]));
                check("sb_illegal", 32'(d2e_illegal), 32'(e[0]));
                if (e[TW+65:66] == T_INSTR) begin
                    check("sb_instr", d2e_instr, ei);
                    check("sb_rd", 32'(d2e_rd), 32'(ei[11:7]));
                    check("sb_rs1", 32'(d2e_rs1), 32'(ei[19:15]));
                    check("sb_rs2", 32'(d2e_rs2), 32'(ei[24:20]));
                end
            end
        end
    end

    // One clock cycle: drive, check the combinational D2F path mid-cycle, record expected acceptance.
    task automatic cyc(input logic fv, input logic [TW-1:0] ft, input logic [31:0] fi,
                       input logic [31:0] fp, input logic er, input logic [CW-1:0] ec,
                       input logic [31:0] et, input logic exp_rdy, input logic ser,
                       input logic ill);
        logic ill_exp;
`ifdef ARMLEOCPU_DECODE_ILLEGAL_CHECK_EN
        ill_exp = ill;
`else
        ill_exp = 1'b0;
`endif
        f2d_valid        = fv;
        f2d_type         = ft;
        f2d_instr        = fi;
        f2d_pc           = fp;
        e2d_ready        = er;
        e2d_cmd          = ec;
        e2d_branchtarget = et;
        @(negedge clk);
        check("d2f_ready", 32'(d2f_ready), 32'(exp_rdy));
        check("d2f_cmd", 32'(d2f_cmd), 32'(ec));
        check("d2f_branchtarget", d2f_branchtarget, (ec == C_NONE) ? 32'd0 : et);
        if (fv && exp_rdy && ec == C_NONE) begin
            exp_q.push_back({ft, fp, fi, ser, ill_exp});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] fi, input logic [31:0] fp, input logic er,
                        input logic exp_rdy, input logic ser, input logic ill);
        cyc(1'b1, T_INSTR, fi, fp, er, C_NONE, 32'd0, exp_rdy, ser, ill);
    endtask

    task automatic idle(input logic er, input logic exp_rdy);
        cyc(1'b0, T_INSTR, 32'd0, 32'd0, er, C_NONE, 32'd0, exp_rdy, 1'b0, 1'b0);
    endtask

    logic [31:0] ill_instr[12] = '{32'h0000_0000, 32'h0000_006F, 32'h4000_0033, 32'h0200_0033,
                                   32'h0000_2063, 32'h4000_1013, 32'h4000_5013, 32'h0000_3003,
                                   32'h0000_1067, 32'h0000_0037, 32'h0000_3023, 32'h4000_4033};
    logic        ill_exp_tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
                                     1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    initial begin
        rst = 1'b1;
        f2d_valid = 1'b1; f2d_type = T_INSTR; f2d_instr = NOP; f2d_pc = 32'h10;
        e2d_ready = 1'b1; e2d_cmd = C_NONE; e2d_branchtarget = 32'd0;

        // Reset: D2F gated off, D2E cleared.
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_d2f_ready", 32'(d2f_ready), 32'd0);
        check("rst_d2f_cmd", 32'(d2f_cmd), 32'(C_NONE));
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_d2e_valid", 32'(d2e_valid), 32'd0);
        check("rst_d2e_pc", d2e_pc, 32'd0);
        check("rst_d2e_instr", d2e_instr, 32'd0);
        check("rst_d2e_type", 32'(d2e_type), 32'd0);
        check("rst_d2e_rd", 32'(d2e_rd), 32'd0);
        check("rst_d2e_illegal", 32'(d2e_illegal), 32'd0);
        check("rst_d2e_serialize", 32'(d2e_serialize), 32'd0);

        // Streaming at full throughput.
        send(32'h0050_0093, 32'h1000, 1'b1, 1'b1, 1'b0, 1'b0);
        check("stream_valid0", 32'(d2e_valid), 32'd1);
        check("stream_pc0", d2e_pc, 32'h1000);
        send(32'h0010_8113, 32'h1004, 1'b1, 1'b1, 1'b0, 1'b0);
        check("stream_pc1", d2e_pc, 32'h1004);
        send(32'h0021_0193, 32'h1008, 1'b1, 1'b1, 1'b0, 1'b0);
        check("stream_pc2", d2e_pc, 32'h1008);
        idle(1'b1, 1'b1);
        check("stream_drained", 32'(d2e_valid), 32'd0);

        // Backpressure: item held, fetch stalled, next item taken when execute frees up.
        send(32'h0050_0093, 32'h1100, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            send(NOP, 32'h1104, 1'b0, 1'b0, 1'b0, 1'b0);
            check("bp_valid", 32'(d2e_valid), 32'd1);
            check("bp_instr", d2e_instr, 32'h0050_0093);
            check("bp_pc", d2e_pc, 32'h1100);
            check("bp_rd", 32'(d2e_rd), 32'd1);
        end
        send(NOP, 32'h1104, 1'b1, 1'b1, 1'b0, 1'b0);
        check("bp_next_pc", d2e_pc, 32'h1104);
        idle(1'b1, 1'b1);

        // Illegal-check table, then random legal ALU traffic.
        for (int i = 0; i < 12; i++) begin
            send(ill_instr[i], 32'h1200 + 32'(i * 4), 1'b1, 1'b1, 1'b0, ill_exp_tbl[i]);
        end
        for (int i = 0; i < 8; i++) begin
            logic [31:0] w;
            if ($urandom_range(0, 1) == 1) begin
                w = {12'($urandom_range(0, 4095)), 5'($urandom_range(0, 31)), 3'b000,
                     5'($urandom_range(0, 31)), 7'b0010011};
            end else begin
                w = {($urandom_range(0, 1) == 1) ? 7'b0100000 : 7'b0000000,
                     5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 3'b000,
                     5'($urandom_range(0, 31)), 7'b0110011};
            end
            send(w, 32'h1300 + 32'(i * 4), 1'b1, 1'b1, 1'b0, 1'b0);
        end
        idle(1'b1, 1'b1);

        // Serialize on CSRRW, released by START_BRANCH to pc+4.
        send(32'h3401_1073, 32'h2000, 1'b1, 1'b1, 1'b1, 1'b0);
        check("ser_d2e_serialize", 32'(d2e_serialize), 32'd1);
        send(NOP, 32'h2004, 1'b1, 1'b0, 1'b0, 1'b0);
        check("ser_drained", 32'(d2e_valid), 32'd0);
        send(NOP, 32'h2004, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, T_INSTR, NOP, 32'h2004, 1'b1, C_BR, 32'h2004, 1'b1, 1'b0, 1'b0);
        check("ser_redirect_valid", 32'(d2e_valid), 32'd0);
        send(NOP, 32'h2004, 1'b1, 1'b1, 1'b0, 1'b0);
        check("ser_resume_pc", d2e_pc, 32'h2004);
        idle(1'b1, 1'b1);

        // Redirect collides with an F2D item: item dropped.
        cyc(1'b1, T_INSTR, NOP, 32'h300, 1'b1, C_FLUSH, 32'h1234_5678, 1'b1, 1'b0, 1'b0);
        check("flush_valid", 32'(d2e_valid), 32'd0);
        idle(1'b1, 1'b1);
        check("flush_still_empty", 32'(d2e_valid), 32'd0);

        // FENCE held by execute across its own redirect.
        send(32'h0000_000F, 32'h400, 1'b1, 1'b1, 1'b1, 1'b0);
        send(NOP, 32'h404, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, T_INSTR, NOP, 32'h404, 1'b0, C_FLUSH, 32'h404, 1'b1, 1'b0, 1'b0);
        check("hold_redirect_valid", 32'(d2e_valid), 32'd1);
        check("hold_redirect_pc", d2e_pc, 32'h400);
        idle(1'b1, 1'b1);
        check("hold_consumed", 32'(d2e_valid), 32'd0);

        // Interrupt token serializes; reset mid-serialize clears everything.
        cyc(1'b1, T_INT, 32'd0, 32'h500, 1'b1, C_NONE, 32'd0, 1'b1, 1'b1, 1'b0);
        send(NOP, 32'h504, 1'b0, 1'b0, 1'b0, 1'b0);
        check("int_valid", 32'(d2e_valid), 32'd1);
        check("int_type", 32'(d2e_type), 32'(T_INT));
        check("int_serialize", 32'(d2e_serialize), 32'd1);
        check("int_illegal", 32'(d2e_illegal), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_d2f_ready", 32'(d2f_ready), 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        check("post_rst_valid", 32'(d2e_valid), 32'd0);
        check("post_rst_pc", d2e_pc, 32'd0);
        send(NOP, 32'h504, 1'b0, 1'b1, 1'b0, 1'b0);
        check("post_rst_accept_pc", d2e_pc, 32'h504);
        idle(1'b1, 1'b1);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
